// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serialising memory controller.
// Latency: n/a (constants, types and pure helpers only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    // dm_width_i encodings; 2'b11 is treated as a word access
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Controller states, kept as plain constants for legacy tooling
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Owner of the access in flight
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // mem_a[17:16] value that selects the IO space; decoded outside this block
    localparam logic [1:0] IO_REGION = 2'b11;

    // Fields latched when a request is accepted
    typedef struct packed {
        logic       port;   // PORT_IF or PORT_DM
        logic       sgn;    // sign-extend byte/half loads
        logic [2:0] len;    // byte count: 1, 2 or 4
    } req_meta_t;

    function automatic logic [2:0] width_to_len(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            WIDTH_WORD: return 3'd4;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic is_io_region(input logic [1:0] addr_hi);
        return addr_hi == IO_REGION;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: core-side fetch and load/store request/response signals.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held by the core until the matching done pulse.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    // Instruction-fetch port
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [31:0]           if_data_o;
    logic                  if_done_o;

    // Load/store port
    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [1:0]            dm_width_i;
    logic                  dm_signed_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [31:0]           dm_wdata_i;
    logic [31:0]           dm_rdata_o;
    logic                  dm_done_o;

    // Core side
    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_width_i, dm_signed_i, dm_addr_i, dm_wdata_i,
        input  if_data_o, if_done_o, dm_rdata_o, dm_done_o
    );

    // Controller side
    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_width_i, dm_signed_i, dm_addr_i, dm_wdata_i,
        output if_data_o, if_done_o, dm_rdata_o, dm_done_o
    );

endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: picks which pending port the controller accepts when it is idle.
// Latency: combinational, no state.
// Backpressure: loser is not acknowledged; its level request stays pending and wins next time.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int FETCH_PRIORITY = 0
) (
    input  logic if_req,
    input  logic dm_req,
    output logic grant_vld,
    output logic grant_port
);

    // Fixed priority on a tie, otherwise whichever port is asking
    always_comb begin
        grant_vld = if_req | dm_req;
        if (if_req && dm_req) begin
            grant_port = (FETCH_PRIORITY != 0) ? PORT_IF : PORT_DM;
        end else if (if_req) begin
            grant_port = PORT_IF;
        end else begin
            grant_port = PORT_DM;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store ports onto the byte-wide RAM/IO bus, one byte beat per cycle.
// Latency: read done at A+n+2, write done at A+n+1 (A = IDLE accept cycle, n = 1/2/4 bytes); next accept after DONE.
// Backpressure: requests held until done; rdy_in low freezes everything and gates mem_wr. Option: MEM_CTRL_SIGN_EXT_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int FETCH_PRIORITY = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    mem_ctrl_if.slave   cif,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    // Latched access
    state_t                state_q;
    req_meta_t             meta_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            cnt_q;
    logic [31:0]           res_q;

    // Registered bus and response outputs
    logic [ADDR_WIDTH-1:0] a_q;
    logic [7:0]            dout_q;
    logic                  wr_q;
    logic [31:0]           if_data_q;
    logic [31:0]           dm_rdata_q;
    logic                  if_done_q;
    logic                  dm_done_q;

    // Acceptance and beat helpers
    logic                  grant_vld;
    logic                  grant_port;
    req_meta_t             acc_meta;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic                  accept;
    logic [2:0]            next_idx;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [7:0]            next_wbyte;
    logic [1:0]            cap_idx;
    logic                  issue_more;
    logic                  read_last;
    logic [31:0]           res_cap;
    logic [31:0]           load_res;

    mem_ctrl_arb #(
        .FETCH_PRIORITY (FETCH_PRIORITY)
    ) u_arb (
        .if_req     (cif.if_req_i),
        .dm_req     (cif.dm_req_i),
        .grant_vld  (grant_vld),
        .grant_port (grant_port)
    );

    // Requests are only looked at while idle
    assign accept = (state_q == ST_IDLE) && grant_vld;

    // cnt_q counts beats within READ/WRITE; byte cnt_q+1 is the next one to put on the bus.
    // In READ, the byte on mem_din belongs to the address issued one cycle earlier (index cnt_q-1).
    assign next_idx   = cnt_q + 3'd1;
    assign next_addr  = addr_q + ADDR_WIDTH'(next_idx);
    assign next_wbyte = wdata_q[{next_idx[1:0], 3'b000} +: 8];
    assign cap_idx    = cnt_q[1:0] - 2'd1;
    assign issue_more = next_idx < meta_q.len;
    assign read_last  = cnt_q == meta_q.len;

    // Select the fields of the granted port; fetch is always an unsigned word read
    always_comb begin
        acc_meta  = '{port: PORT_DM, sgn: 1'b0, len: 3'd4};
        acc_we    = 1'b0;
        acc_addr  = cif.dm_addr_i;
        acc_wdata = cif.dm_wdata_i;
        if (grant_port == PORT_IF) begin
            acc_meta  = '{port: PORT_IF, sgn: 1'b0, len: 3'd4};
            acc_addr  = cif.if_addr_i;
            acc_wdata = '0;
        end else begin
            acc_meta = '{port: PORT_DM, sgn: cif.dm_signed_i, len: width_to_len(cif.dm_width_i)};
            acc_we   = cif.dm_we_i;
        end
    end

    // Merge the byte arriving on mem_din into the partial result; unfilled bytes stay zero
    always_comb begin
        res_cap = res_q;
        res_cap[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    // Final load value, optionally sign-extended for byte/half loads
    always_comb begin
        load_res = res_cap;
`ifdef MEM_CTRL_SIGN_EXT_EN
        if (meta_q.sgn) begin
            if (meta_q.len == 3'd1) begin
                load_res = {{24{res_cap[7]}}, res_cap[7:0]};
            end else if (meta_q.len == 3'd2) begin
                load_res = {{16{res_cap[15]}}, res_cap[15:0]};
            end
        end
`endif
    end

`ifndef MEM_CTRL_SIGN_EXT_EN
    // The core performs extension itself in this build
    logic unused_sgn;
    assign unused_sgn = meta_q.sgn;
`endif

    // State sequencing and latching of the accepted request
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            meta_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        meta_q  <= acc_meta;
                        addr_q  <= acc_addr;
                        wdata_q <= acc_wdata;
                        cnt_q   <= '0;
                        state_q <= acc_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (read_last) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= next_idx;
                    end
                end
                ST_WRITE: begin
                    if (issue_more) begin
                        cnt_q <= next_idx;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive address, write data and write strobe one byte per cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            a_q    <= '0;
            dout_q <= '0;
            wr_q   <= 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q  <= acc_addr;
                        wr_q <= acc_we;
                        if (acc_we) begin
                            dout_q <= acc_wdata[7:0];
                        end
                    end
                end
                ST_READ: begin
                    if (issue_more) begin
                        a_q <= next_addr;
                    end
                end
                ST_WRITE: begin
                    if (issue_more) begin
                        a_q    <= next_addr;
                        dout_q <= next_wbyte;
                    end else begin
                        wr_q <= 1'b0;
                    end
                end
                default: begin
                    wr_q <= 1'b0;
                end
            endcase
        end
    end

    // Collect read bytes and publish results with single-cycle done pulses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            res_q      <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        res_q <= '0;
                    end
                end
                ST_READ: begin
                    if (cnt_q != 3'd0) begin
                        res_q <= res_cap;
                    end
                    if (read_last) begin
                        if (meta_q.port == PORT_IF) begin
                            if_data_q <= res_cap;
                            if_done_q <= 1'b1;
                        end else begin
                            dm_rdata_q <= load_res;
                            dm_done_q  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!issue_more) begin
                        dm_done_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus address is zero-extended to the full pin width
    always_comb begin
        mem_a                   = '0;
        mem_a[ADDR_WIDTH-1:0]   = a_q;
    end

    // The memory is frozen with rdy_in, so a write strobe must never leak out while it is low
    assign mem_wr   = wr_q & rdy_in;
    assign mem_dout = dout_q;

    assign cif.if_data_o  = if_data_q;
    assign cif.if_done_o  = if_done_q;
    assign cif.dm_rdata_o = dm_rdata_q;
    assign cif.dm_done_o  = dm_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table vectors plus hand-written multi-cycle sequences for mem_ctrl.
// Latency: cycle offsets are measured from the cycle in which the request is first presented.
// Backpressure: a byte-wide memory model frozen by rdy, with one cycle of read latency.
module tb_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int cyc;
    int checks;
    int failures;

    logic [7:0] mem [0:1023];

`ifdef MEM_CTRL_SIGN_EXT_EN
    localparam logic SX = 1'b1;
`else
    localparam logic SX = 1'b0;
`endif

    mem_ctrl_if #(.ADDR_WIDTH(32)) cif ();

    mem_ctrl #(
        .ADDR_WIDTH     (32),
        .FETCH_PRIORITY (0)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .rdy_in   (rdy),
        .cif      (cif),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int midx(input logic [31:0] a);
        return int'({a[17:16], a[7:0]});
    endfunction

    // Byte memory: read data for the address of cycle t appears in t+1; frozen with rdy
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= mem[midx(mem_a)];
            if (mem_wr) mem[midx(mem_a)] = mem_dout;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        for (int b = 0; b < 4; b++) mem[midx(addr + 32'(b))] = val[8*b +: 8];
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] addr);
        return {mem[midx(addr + 32'd3)], mem[midx(addr + 32'd2)],
                mem[midx(addr + 32'd1)], mem[midx(addr)]};
    endfunction

    // One data-port access; lat is the done offset from the request cycle, -1 on timeout
    task automatic run_dm(input logic we, input logic [1:0] w, input logic s,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        int a0;
        lat = -1;
        rd  = '0;
        cif.dm_we_i     = we;
        cif.dm_width_i  = w;
        cif.dm_signed_i = s;
        cif.dm_addr_i   = addr;
        cif.dm_wdata_i  = wd;
        cif.dm_req_i    = 1'b1;
        a0 = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            if (cif.dm_done_o) begin
                lat = cyc - a0;
                rd  = cif.dm_rdata_o;
                break;
            end
        end
        cif.dm_req_i = 1'b0;
        step();
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;    // memory bytes at addr..addr+3 before the access
        logic [31:0] want;   // load result, or memory bytes after a store
        int          lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          a0;
        int          off;
        int          lat;
        int          dm_at;
        int          if_at;
        logic [31:0] rd;
        logic [31:0] data;
        logic [31:0] last_rd;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h4433_2211, 32'h4433_2211, 6};
        vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'h0, 32'h0000_009A, 32'h0000_009A, 3};
        vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0050, 32'h0, 32'h0000_12F0,
                   SX ? 32'hFFFF_FFF0 : 32'h0000_00F0, 3};
        vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0061, 32'h0, 32'hFFFF_7BCD, 32'h0000_7BCD, 4};
        vt[4]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0071, 32'hDEAD_BEEF, 32'h0, 32'h0000_BEEF, 3};
        vt[5]  = '{1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0403_0201, 32'h0403_0201, 6};
        vt[6]  = '{1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h8765_4321, 32'hAAAA_AAAA, 32'h8765_4321, 5};
        vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0080, 32'h0, 32'h0000_9000,
                   SX ? 32'hFFFF_9000 : 32'h0000_9000, 4};
        vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0092, 32'h0000_00C7, 32'h1111_1111, 32'h1111_11C7, 2};
        vt[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_00B0, 32'h0, 32'h0000_8034,
                   SX ? 32'hFFFF_8034 : 32'h0000_8034, 4};
        vt[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_00C0, 32'h0, 32'h0000_0085, 32'h0000_0085, 3};

        rst_n           = 1'b0;
        rdy             = 1'b1;
        cif.if_req_i    = 1'b0;
        cif.if_addr_i   = '0;
        cif.dm_req_i    = 1'b0;
        cif.dm_we_i     = 1'b0;
        cif.dm_width_i  = 2'b00;
        cif.dm_signed_i = 1'b0;
        cif.dm_addr_i   = '0;
        cif.dm_wdata_i  = '0;

        // Reset state
        step();
        step();
        check("rst_if_data",  cif.if_data_o,  32'h0);
        check("rst_dm_rdata", cif.dm_rdata_o, 32'h0);
        check("rst_mem_a",    mem_a,          32'h0);
        check("rst_mem_dout", 32'(mem_dout),  32'h0);
        check("rst_mem_wr",   32'(mem_wr),    32'h0);
        check("rst_if_done",  32'(cif.if_done_o), 32'h0);
        check("rst_dm_done",  32'(cif.dm_done_o), 32'h0);
        rst_n = 1'b1;
        step();

        // Word fetch at 0x100: addresses at A+1..A+4, done at A+6
        set_word(32'h100, 32'h0000_0513);
        cif.if_addr_i = 32'h100;
        cif.if_req_i  = 1'b1;
        a0   = cyc;
        lat  = -1;
        data = '0;
        for (int k = 0; k < 40; k++) begin
            step();
            off = cyc - a0;
            if (off >= 1 && off <= 4) check($sformatf("fetch_mem_a_A+%0d", off), mem_a, 32'h100 + 32'(off - 1));
            if (cif.if_done_o) begin
                lat  = off;
                data = cif.if_data_o;
                break;
            end
        end
        cif.if_req_i = 1'b0;
        check("fetch_latency", 32'(lat), 32'd6);
        check("fetch_data", data, 32'h0000_0513);
        step();

        // Byte store to the IO region: one write beat at A+1, done at A+2
        cif.dm_we_i    = 1'b1;
        cif.dm_width_i = 2'b00;
        cif.dm_addr_i  = 32'h0003_0000;
        cif.dm_wdata_i = 32'h0000_00AB;
        cif.dm_req_i   = 1'b1;
        step();
        check("stb_wr_A+1",   32'(mem_wr),   32'h1);
        check("stb_a_A+1",    mem_a,         32'h0003_0000);
        check("stb_dout_A+1", 32'(mem_dout), 32'h0000_00AB);
        step();
        check("stb_wr_A+2",   32'(mem_wr),        32'h0);
        check("stb_done_A+2", 32'(cif.dm_done_o), 32'h1);
        cif.dm_req_i = 1'b0;
        step();
        check("stb_mem", 32'(mem[midx(32'h0003_0000)]), 32'h0000_00AB);

        // Simultaneous requests: half load wins, fetch accepted the cycle after DONE
        set_word(32'h20, 32'h0000_2211);
        cif.dm_we_i     = 1'b0;
        cif.dm_width_i  = 2'b01;
        cif.dm_signed_i = 1'b0;
        cif.dm_addr_i   = 32'h20;
        cif.dm_req_i    = 1'b1;
        cif.if_addr_i   = 32'h100;
        cif.if_req_i    = 1'b1;
        a0    = cyc;
        dm_at = -1;
        if_at = -1;
        data  = '0;
        for (int k = 0; k < 60; k++) begin
            step();
            off = cyc - a0;
            if (off == 6) check("arb_fetch_first_a", mem_a, 32'h100);
            if (cif.dm_done_o) begin
                dm_at = off;
                cif.dm_req_i = 1'b0;
                check("arb_load_data", cif.dm_rdata_o, 32'h0000_2211);
            end
            if (cif.if_done_o) begin
                if_at = off;
                data  = cif.if_data_o;
                cif.if_req_i = 1'b0;
                break;
            end
        end
        cif.dm_req_i = 1'b0;
        cif.if_req_i = 1'b0;
        check("arb_load_done",  32'(dm_at), 32'd4);
        check("arb_fetch_done", 32'(if_at), 32'd11);
        check("arb_fetch_data", data, 32'h0000_0513);
        step();

        // Table vectors
        last_rd = 32'h0000_2211;
        for (int v = 0; v < NV; v++) begin
            set_word(vt[v].addr, vt[v].pre);
            run_dm(vt[v].we, vt[v].width, vt[v].sgn, vt[v].addr, vt[v].wdata, lat, rd);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vt[v].lat));
            if (vt[v].we) begin
                check($sformatf("vec%0d_mem", v), get_word(vt[v].addr), vt[v].want);
                check($sformatf("vec%0d_rdata_kept", v), rd, last_rd);
            end else begin
                check($sformatf("vec%0d_rdata", v), rd, vt[v].want);
                last_rd = vt[v].want;
            end
        end
        check("if_data_kept", cif.if_data_o, 32'h0000_0513);

        // rdy low for 3 cycles during a word read: state holds, done 3 cycles late
        set_word(32'h40, 32'hD4C3_B2A1);
        cif.dm_we_i    = 1'b0;
        cif.dm_width_i = 2'b10;
        cif.dm_signed_i = 1'b0;
        cif.dm_addr_i  = 32'h40;
        cif.dm_req_i   = 1'b1;
        a0  = cyc;
        lat = -1;
        rd  = '0;
        for (int k = 0; k < 40; k++) begin
            step();
            off = cyc - a0;
            if (off >= 3 && off <= 5) begin
                check($sformatf("frz_rd_a_A+%0d", off), mem_a, 32'h41);
                check($sformatf("frz_rd_wr_A+%0d", off), 32'(mem_wr), 32'h0);
            end
            if (off == 2) rdy = 1'b0;
            if (off == 5) rdy = 1'b1;
            if (cif.dm_done_o) begin
                lat = off;
                rd  = cif.dm_rdata_o;
                break;
            end
        end
        rdy = 1'b1;
        cif.dm_req_i = 1'b0;
        check("frz_rd_latency", 32'(lat), 32'd9);
        check("frz_rd_data", rd, 32'hD4C3_B2A1);
        step();

        // rdy low for 2 cycles during a word store: write strobe suppressed, no byte lost
        set_word(32'h90, 32'h0);
        cif.dm_we_i    = 1'b1;
        cif.dm_width_i = 2'b10;
        cif.dm_addr_i  = 32'h90;
        cif.dm_wdata_i = 32'h1122_3344;
        cif.dm_req_i   = 1'b1;
        a0  = cyc;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            off = cyc - a0;
            if (off == 2) begin
                rdy = 1'b0;
                #1;
                check("frz_wr_gate_A+2", 32'(mem_wr), 32'h0);
            end
            if (off == 3) begin
                check("frz_wr_gate_A+3", 32'(mem_wr), 32'h0);
                check("frz_wr_a_A+3", mem_a, 32'h91);
            end
            if (off == 4) begin
                rdy = 1'b1;
                #1;
                check("frz_wr_resume_A+4", 32'(mem_wr), 32'h1);
            end
            if (cif.dm_done_o) begin
                lat = off;
                break;
            end
        end
        rdy = 1'b1;
        cif.dm_req_i = 1'b0;
        check("frz_wr_latency", 32'(lat), 32'd7);
        step();
        check("frz_wr_mem", get_word(32'h90), 32'h1122_3344);

        // Reset at A+3 of a word store: outputs clear at once, no done, re-issue completes
        set_word(32'hA0, 32'h0);
        cif.dm_we_i    = 1'b1;
        cif.dm_width_i = 2'b10;
        cif.dm_addr_i  = 32'hA0;
        cif.dm_wdata_i = 32'h5566_7788;
        cif.dm_req_i   = 1'b1;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_wr",   32'(mem_wr),        32'h0);
        check("rstmid_mem_a",    mem_a,              32'h0);
        check("rstmid_mem_dout", 32'(mem_dout),      32'h0);
        check("rstmid_dm_done",  32'(cif.dm_done_o), 32'h0);
        check("rstmid_if_data",  cif.if_data_o,      32'h0);
        check("rstmid_dm_rdata", cif.dm_rdata_o,     32'h0);
        cif.dm_req_i = 1'b0;
        step();
        step();
        check("rstmid_no_done", 32'(cif.dm_done_o), 32'h0);
        rst_n = 1'b1;
        run_dm(1'b1, 2'b10, 1'b0, 32'hA0, 32'h5566_7788, lat, rd);
        check("rstmid_reissue_latency", 32'(lat), 32'd5);
        check("rstmid_reissue_mem", get_word(32'hA0), 32'h5566_7788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
